// File: rtl/path_count_engine.sv
// path_count_engine
//
// Forward-pass path counter over a topologically ordered node stream.
// For each of CHANNELS (source, sink) pairs it keeps a count RAM. Every ordered
// node u with a non-zero count in some channel has its successors fetched
// through the adjacency query/reply interface. Each successor v then gets
// count[v] += count[u] in every channel, with saturating arithmetic.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse, latches src_nodes/dst_nodes (ignored while busy)
//   src_nodes         per-channel source index, channel c at [c*NODE_WIDTH +: NODE_WIDTH]
//   dst_nodes         per-channel sink index, same packing
//   order_*           topological order stream (valid/ready, last marks final node)
//   query_*           successor request for node u (valid/ready)
//   reply_*           successor beats (valid/ready, last ends list, empty = no successors)
//   busy              run in progress
//   result_valid      one-cycle pulse when result_data is updated
//   result_data       per-channel count at the sink, channel c at [c*COUNT_WIDTH +: COUNT_WIDTH]
//   overflow          sticky per-channel saturation flag, cleared by an accepted start
//
// Handshakes: a beat transfers on a clk edge where valid and ready are both
// high. query_valid/query_data hold steady until query_ready is seen.
module path_count_engine #(
    parameter int MAX_NODES   = 1024,
    parameter int NODE_WIDTH  = $clog2(MAX_NODES),
    parameter int CHANNELS    = 2,
    parameter int COUNT_WIDTH = 48
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [CHANNELS*NODE_WIDTH-1:0]  src_nodes,
    input  logic [CHANNELS*NODE_WIDTH-1:0]  dst_nodes,
    input  logic                            order_valid,
    output logic                            order_ready,
    input  logic [NODE_WIDTH-1:0]           order_node,
    input  logic                            order_last,
    input  logic                            query_ready,
    output logic                            query_valid,
    output logic [NODE_WIDTH-1:0]           query_data,
    input  logic                            reply_valid,
    output logic                            reply_ready,
    input  logic                            reply_last,
    input  logic                            reply_empty,
    input  logic [NODE_WIDTH-1:0]           reply_data,
    output logic                            busy,
    output logic                            result_valid,
    output logic [CHANNELS*COUNT_WIDTH-1:0] result_data,
    output logic [CHANNELS-1:0]             overflow
);

    localparam int W      = COUNT_WIDTH;
    localparam int CH_W   = $clog2(CHANNELS + 1);
    // One shared counter sequences CLEAR, SEED, the two READ_U cycles and COLLECT.
    localparam int CNT_W  = ((NODE_WIDTH > CH_W) ? NODE_WIDTH : CH_W) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_SEED, S_WAIT_ORDER, S_READ_U, S_QUERY,
        S_WAIT_REPLY, S_RMW_RD, S_RMW_WR, S_NEXT, S_COLLECT, S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NODE_WIDTH-1:0]        u_q, u_d;
    logic                         u_last_q, u_last_d;
    logic [NODE_WIDTH-1:0]        v_q, v_d;
    logic                         v_last_q, v_last_d;
    logic [CHANNELS*W-1:0]        hold_q, hold_d;
    logic [CHANNELS*NODE_WIDTH-1:0] src_q, src_d;
    logic [CHANNELS*NODE_WIDTH-1:0] dst_q, dst_d;
    logic [CHANNELS*W-1:0]        result_q, result_d;
    logic [CHANNELS-1:0]          overflow_q, overflow_d;

    // Count RAMs: one shared address, per-channel write enables, 1-cycle read.
    logic [NODE_WIDTH-1:0]        ram_addr;
    logic [CHANNELS-1:0]          ram_we;
    logic [CHANNELS*W-1:0]        ram_wdata;
    logic [CHANNELS*W-1:0]        ram_rdata;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ram
        logic [W-1:0] mem [MAX_NODES];
        logic [W-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (ram_we[g]) begin
                mem[ram_addr] <= ram_wdata[g*W +: W];
            end
            rdata_q <= mem[ram_addr];
        end
        assign ram_rdata[g*W +: W] = rdata_q;
    end

    // Source/sink of the channel selected by cnt_q (SEED and COLLECT).
    logic [NODE_WIDTH-1:0] sel_src, sel_dst;
    always_comb begin
        sel_src = '0;
        sel_dst = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cnt_q == CNT_W'(c)) begin
                sel_src = src_q[c*NODE_WIDTH +: NODE_WIDTH];
                sel_dst = dst_q[c*NODE_WIDTH +: NODE_WIDTH];
            end
        end
    end

    logic [W:0] sum;

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        u_d        = u_q;
        u_last_d   = u_last_q;
        v_d        = v_q;
        v_last_d   = v_last_q;
        hold_d     = hold_q;
        src_d      = src_q;
        dst_d      = dst_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        ram_addr   = '0;
        ram_we     = '0;
        ram_wdata  = '0;
        sum        = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d      = src_nodes;
                    dst_d      = dst_nodes;
                    overflow_d = '0;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ram_addr = cnt_q[NODE_WIDTH-1:0];
                ram_we   = '1;
                if (cnt_q == CNT_W'(MAX_NODES - 1)) state_d = S_SEED;
                else                                 cnt_d   = cnt_q + 1'b1;
            end
            S_SEED: begin
                ram_addr = sel_src;
                for (int c = 0; c < CHANNELS; c++) begin
                    ram_we[c]          = (cnt_q == CNT_W'(c));
                    ram_wdata[c*W +: W] = W'(1);
                end
                if (cnt_q == CNT_W'(CHANNELS - 1)) state_d = S_WAIT_ORDER;
                else                                cnt_d   = cnt_q + 1'b1;
            end
            S_WAIT_ORDER: begin
                if (order_valid) begin
                    u_d      = order_node;
                    u_last_d = order_last;
                    state_d  = S_READ_U;
                end
            end
            S_READ_U: begin
                // cnt_q==0 issues the read, cnt_q==1 sees the data.
                ram_addr = u_q;
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    hold_d = ram_rdata;
                    if (ram_rdata == '0) state_d = u_last_q ? S_COLLECT : S_WAIT_ORDER;
                    else                 state_d = S_QUERY;
                end
            end
            S_QUERY: begin
                if (query_ready) state_d = S_WAIT_REPLY;
            end
            S_WAIT_REPLY: begin
                if (reply_valid) begin
                    if (reply_empty) begin
                        state_d = S_NEXT;
                    end else begin
                        v_d      = reply_data;
                        v_last_d = reply_last;
                        state_d  = S_RMW_RD;
                    end
                end
            end
            S_RMW_RD: begin
                ram_addr = v_q;
                state_d  = S_RMW_WR;
            end
            S_RMW_WR: begin
                ram_addr = v_q;
                ram_we   = '1;
                for (int c = 0; c < CHANNELS; c++) begin
                    sum = {1'b0, ram_rdata[c*W +: W]} + {1'b0, hold_q[c*W +: W]};
                    if (sum[W]) begin
                        ram_wdata[c*W +: W] = '1;
                        overflow_d[c]       = 1'b1;
                    end else begin
                        ram_wdata[c*W +: W] = sum[W-1:0];
                    end
                end
                state_d = v_last_q ? S_NEXT : S_WAIT_REPLY;
            end
            S_NEXT: begin
                state_d = u_last_q ? S_COLLECT : S_WAIT_ORDER;
            end
            S_COLLECT: begin
                // Read for channel cnt_q lands one cycle later as channel cnt_q-1.
                ram_addr = sel_dst;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (cnt_q == CNT_W'(c + 1)) result_d[c*W +: W] = ram_rdata[c*W +: W];
                end
                if (cnt_q == CNT_W'(CHANNELS)) state_d = S_DONE;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            u_q        <= '0;
            u_last_q   <= 1'b0;
            v_q        <= '0;
            v_last_q   <= 1'b0;
            hold_q     <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            result_q   <= '0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            u_q        <= u_d;
            u_last_q   <= u_last_d;
            v_q        <= v_d;
            v_last_q   <= v_last_d;
            hold_q     <= hold_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign order_ready  = (state_q == S_WAIT_ORDER);
    assign query_valid  = (state_q == S_QUERY);
    assign query_data   = u_q;
    assign reply_ready  = (state_q == S_WAIT_REPLY);
    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_DONE);
    assign result_data  = result_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_path_count_engine.sv
// Directed bench for path_count_engine (MAX_NODES=16, CHANNELS=2, COUNT_WIDTH=4).
// An order driver and an adjacency responder model the neighbouring blocks.
// Graphs and expected counts below are worked out by hand.
module tb_path_count_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  src_nodes;
  logic [7:0]  dst_nodes;
  logic        order_valid;
  logic        order_ready;
  logic [3:0]  order_node;
  logic        order_last;
  logic        query_ready;
  logic        query_valid;
  logic [3:0]  query_data;
  logic        reply_valid;
  logic        reply_ready;
  logic        reply_last;
  logic        reply_empty;
  logic [3:0]  reply_data;
  logic        busy;
  logic        result_valid;
  logic [7:0]  result_data;
  logic [1:0]  overflow;

  path_count_engine #(
    .MAX_NODES(16), .NODE_WIDTH(4), .CHANNELS(2), .COUNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_nodes(src_nodes), .dst_nodes(dst_nodes),
    .order_valid(order_valid), .order_ready(order_ready),
    .order_node(order_node), .order_last(order_last),
    .query_ready(query_ready), .query_valid(query_valid), .query_data(query_data),
    .reply_valid(reply_valid), .reply_ready(reply_ready), .reply_last(reply_last),
    .reply_empty(reply_empty), .reply_data(reply_data),
    .busy(busy), .result_valid(result_valid), .result_data(result_data),
    .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // graph model
  logic [3:0] adj [16][4];
  int         adj_n [16];
  logic [3:0] ord [16];
  int         o_len = 0;
  int         o_idx = 0;
  logic       queried [16];
  int         stall_left = 0;
  int         max_hold = 0;
  bit         hold_reply = 0;

  // scoreboard
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // order driver: presents ord[o_idx] while o_idx < o_len
  bit o_fire;
  initial begin
    order_valid = 1'b0; order_node = '0; order_last = 1'b0;
    forever begin
      @(negedge clk);
      o_fire = order_valid && order_ready;
      @(posedge clk); #1;
      if (o_fire) o_idx++;
      if (o_idx < o_len) begin
        order_valid = 1'b1;
        order_node  = ord[o_idx];
        order_last  = (o_idx == o_len - 1);
      end else begin
        order_valid = 1'b0;
        order_last  = 1'b0;
      end
    end
  end

  // adjacency responder
  int         cur = 0;
  int         beat = 0;
  int         hold_run = 0;
  bit         q_pend = 0;
  logic [3:0] q_prev = '0;
  bit         qv, q_fire, r_fire;
  logic [3:0] qd;

  task present_beat();
    reply_valid = 1'b1;
    reply_empty = (adj_n[cur] == 0);
    reply_data  = (adj_n[cur] == 0) ? 4'd0 : adj[cur][beat];
    reply_last  = (beat >= adj_n[cur] - 1);
  endtask

  initial begin
    query_ready = 1'b0; reply_valid = 1'b0; reply_last = 1'b0;
    reply_empty = 1'b0; reply_data = '0;
    forever begin
      @(negedge clk);
      qv     = query_valid;
      qd     = query_data;
      q_fire = qv && query_ready;
      r_fire = reply_valid && reply_ready;
      if (qv && q_pend) begin
        check("query_hold", {28'd0, qd}, {28'd0, q_prev});
        hold_run++;
        if (hold_run > max_hold) max_hold = hold_run;
      end else begin
        hold_run = 0;
      end
      q_pend = qv && !q_fire;
      q_prev = qd;
      @(posedge clk); #1;
      if (q_fire) begin
        query_ready = 1'b0;
        queried[qd] = 1'b1;
        cur  = int'(qd);
        beat = 0;
        if (!hold_reply) present_beat();
      end else if (r_fire) begin
        beat++;
        if (beat >= ((adj_n[cur] == 0) ? 1 : adj_n[cur])) begin
          reply_valid = 1'b0; reply_last = 1'b0; reply_empty = 1'b0;
        end else begin
          present_beat();
        end
      end else if (qv && !query_ready) begin
        if (stall_left > 0) stall_left--;
        else                query_ready = 1'b1;
      end
    end
  end

  // driver tasks
  task clear_graph();
    for (int i = 0; i < 16; i++) begin
      adj_n[i]   = 0;
      queried[i] = 1'b0;
    end
    o_len = 0;
  endtask

  task add_edge(input int u, input int v);
    adj[u][adj_n[u]] = 4'(v);
    adj_n[u]++;
  endtask

  task add_order(input int n);
    ord[o_len] = 4'(n);
    o_len++;
  endtask

  task check_idle_outputs(input string pfx);
    check({pfx, "_order_ready"},  {31'd0, order_ready},  0);
    check({pfx, "_query_valid"},  {31'd0, query_valid},  0);
    check({pfx, "_reply_ready"},  {31'd0, reply_ready},  0);
    check({pfx, "_busy"},         {31'd0, busy},         0);
    check({pfx, "_result_valid"}, {31'd0, result_valid}, 0);
    check({pfx, "_result_data"},  {24'd0, result_data},  0);
    check({pfx, "_overflow"},     {30'd0, overflow},     0);
  endtask

  // One run: start pulse, wait for result_valid, compare against the scoreboard.
  // busy_at > 0 pulses a stray start (with swapped src/dst) that many cycles in.
  task run_graph(input int s0, input int d0, input int s1, input int d1,
                 input logic [3:0] e0, input logic [3:0] e1,
                 input logic [1:0] eov, input int busy_at);
    logic [3:0] x0, x1;
    bit seen;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    o_idx = 0;
    @(posedge clk); #2;
    start     = 1'b1;
    src_nodes = {4'(s1), 4'(s0)};
    dst_nodes = {4'(d1), 4'(d0)};
    @(negedge clk);
    check("busy_in_start_cycle", {31'd0, busy}, 0);
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", {31'd0, busy}, 1);
    seen = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      start = (busy_at > 0) && (k == busy_at);
      if (start) begin
        src_nodes = {4'(s0), 4'(s1)};
        dst_nodes = {4'(d0), 4'(d1)};
      end
      if (result_valid) begin
        seen = 1;
        break;
      end
    end
    start = 1'b0;
    x0 = exp_q.pop_front();
    x1 = exp_q.pop_front();
    check("result_valid_seen", {31'd0, seen}, 1);
    if (seen) begin
      check("result_ch0", {28'd0, result_data[3:0]}, {28'd0, x0});
      check("result_ch1", {28'd0, result_data[7:4]}, {28'd0, x1});
      check("overflow",   {30'd0, overflow},         {30'd0, eov});
      check("busy_in_done", {31'd0, busy}, 1);
      @(negedge clk);
      check("result_valid_pulse", {31'd0, result_valid}, 0);
      check("busy_after_done",    {31'd0, busy},         0);
      check("result_hold_ch0", {28'd0, result_data[3:0]}, {28'd0, x0});
    end
  endtask

  task diamond();
    clear_graph();
    add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
    for (int i = 0; i < 4; i++) add_order(i);
  endtask

  bit seen_wr;

  initial begin
    rst = 1'b1; start = 1'b0; src_nodes = '0; dst_nodes = '0;
    clear_graph();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // diamond: (0,3) -> 2, (1,3) -> 1
    diamond();
    run_graph(0, 3, 1, 3, 4'd2, 4'd1, 2'b00, 0);

    // puzzle example: aaa=0 you=1 hhh=2 bbb=3 ccc=4 ddd=5 eee=6 fff=7 ggg=8 iii=9 out=10
    clear_graph();
    add_edge(0, 1); add_edge(0, 2);
    add_edge(1, 3); add_edge(1, 4);
    add_edge(3, 5); add_edge(3, 6);
    add_edge(4, 5); add_edge(4, 6); add_edge(4, 7);
    add_edge(5, 8); add_edge(6, 10); add_edge(7, 10); add_edge(8, 10);
    add_edge(2, 4); add_edge(2, 7); add_edge(2, 9);
    add_edge(9, 10);
    add_order(0); add_order(2); add_order(9); add_order(1); add_order(3); add_order(4);
    add_order(5); add_order(6); add_order(7); add_order(8); add_order(10);
    run_graph(1, 10, 0, 10, 4'd5, 4'd10, 2'b00, 0);

    // four chained diamonds: true count 16 saturates to 15 on channel 0
    clear_graph();
    for (int k = 0; k < 4; k++) begin
      add_edge(3*k, 3*k+1); add_edge(3*k, 3*k+2);
      add_edge(3*k+1, 3*k+3); add_edge(3*k+2, 3*k+3);
    end
    for (int i = 0; i <= 12; i++) add_order(i);
    run_graph(0, 12, 11, 12, 4'd15, 4'd1, 2'b01, 0);

    // zero-count nodes 0,1 skipped; node 4 replies empty; first query stalled
    clear_graph();
    add_edge(0, 4); add_edge(1, 4); add_edge(2, 3); add_edge(2, 4); add_edge(3, 4);
    for (int i = 0; i < 5; i++) add_order(i);
    stall_left = 5;
    max_hold   = 0;
    run_graph(2, 4, 2, 3, 4'd2, 4'd1, 2'b00, 0);
    check("no_query_node0", {31'd0, queried[0]}, 0);
    check("no_query_node1", {31'd0, queried[1]}, 0);
    check("query_node2",    {31'd0, queried[2]}, 1);
    check("query_node4",    {31'd0, queried[4]}, 1);
    check("stall_consumed", stall_left, 0);
    check("query_held_5",   {31'd0, (max_hold >= 5)}, 1);

    // sink before source -> 0, source == sink -> 1
    for (int i = 0; i < 16; i++) queried[i] = 1'b0;
    run_graph(3, 1, 4, 4, 4'd0, 4'd1, 2'b00, 0);
    check("skip_node2", {31'd0, queried[2]}, 0);
    check("query_node3", {31'd0, queried[3]}, 1);

    // reset while waiting for a reply
    diamond();
    hold_reply = 1;
    o_idx = 0;
    @(posedge clk); #2;
    start = 1'b1; src_nodes = {4'd1, 4'd0}; dst_nodes = {4'd3, 4'd3};
    @(posedge clk); #2;
    start = 1'b0;
    seen_wr = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (reply_ready) begin
        seen_wr = 1;
        break;
      end
    end
    check("reached_wait_reply", {31'd0, seen_wr}, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrun_reset");
    rst = 1'b0;
    hold_reply = 0;
    o_len = 0;
    repeat (2) @(negedge clk);

    // rerun diamond with a stray start while busy
    diamond();
    run_graph(0, 3, 1, 3, 4'd2, 4'd1, 2'b00, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/path_count_engine.md
# path_count_engine

Forward-pass path counter for the day-11 device graph: consumes the topologically sorted node stream, walks each node's successors through the adjacency map query/reply interface, and accumulates per-node path counts for `CHANNELS` independent (source, sink) pairs in parallel. It sits between `topological_sort`/`adjacency_map` and `tap_encoder`. It generalises the single-pair forward pass to configurable node depth, count width and channel count. It also adds saturation and overflow reporting.

## Interface
Parameters:
- `MAX_NODES`, 1024, number of node count entries per channel
- `NODE_WIDTH`, `$clog2(MAX_NODES)`, node index width
- `CHANNELS`, 2, independent (source, sink) pairs evaluated in one pass
- `COUNT_WIDTH`, 48, path count width per channel; arithmetic saturates

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: `tck` domain clock
- `rst` in 1: synchronous active-high reset
- `start` in 1: single-cycle pulse; latches `src_nodes`/`dst_nodes` and begins a run
- `src_nodes` in CHANNELS*NODE_WIDTH: per-channel source index; channel c uses slice [c*NODE_WIDTH +: NODE_WIDTH]
- `dst_nodes` in CHANNELS*NODE_WIDTH: per-channel sink index, same packing
- `order_valid` in 1: topologically ordered node available
- `order_ready` out 1: engine accepts order beat
- `order_node` in NODE_WIDTH: node index
- `order_last` in 1: final node of the order
- `query_ready` in 1: adjacency map accepts query
- `query_valid` out 1: successor query pending
- `query_data` out NODE_WIDTH: node whose successors are requested
- `reply_valid` in 1: successor beat valid
- `reply_ready` out 1: engine accepts successor beat
- `reply_last` in 1: final beat of the reply
- `reply_empty` in 1: qualifies a beat (always with `reply_last`) meaning no successors; `reply_data` is ignored
- `reply_data` in NODE_WIDTH: successor index
- `busy` out 1: run in progress
- `result_valid` out 1: single-cycle pulse; results stable until next `start`
- `result_data` out CHANNELS*COUNT_WIDTH: count at each channel's sink
- `overflow` out CHANNELS: sticky per-channel saturation flag

## Operation
- Storage: `CHANNELS` count RAMs of MAX_NODES x COUNT_WIDTH. All channels share one address per cycle and have 1-cycle synchronous read latency.
- FSM states:
  - IDLE: `start` → CLEAR.
  - CLEAR: writes 0 to addresses 0..MAX_NODES-1, one per cycle, all channels → SEED.
  - SEED: writes count[src_c]=1 for each channel c, one channel per cycle; CHANNELS cycles → WAIT_ORDER.
  - WAIT_ORDER: `order_ready`=1; handshake latches u and the last flag → READ_U.
  - READ_U: reads count[u] for all channels into a hold register (2 cycles). If all channels read zero, skip the query: go to COLLECT if last, else WAIT_ORDER. Otherwise go to QUERY.
  - QUERY: `query_valid`=1, `query_data`=u until `query_ready` → WAIT_REPLY.
  - WAIT_REPLY: `reply_ready`=1. A handshake with `reply_empty` goes to NEXT. Otherwise latch v → RMW_RD.
  - RMW_RD: read count[v].
  - RMW_WR: for every channel c, count[v] = sat(count[v] + hold[c]). If the raw sum ≥ 2^COUNT_WIDTH, write all-ones and set `overflow[c]`. If the beat was last → NEXT, else → WAIT_REPLY.
  - NEXT: if u was last → COLLECT, else → WAIT_ORDER.
  - COLLECT: reads count[dst_c] per channel into `result_data`; CHANNELS+1 cycles → DONE.
  - DONE: pulses `result_valid` for one cycle → IDLE.
- `start` is ignored while `busy`.
- Nodes absent from the order stream keep count 0. A sink ordered before its source yields 0.
- A channel whose source equals its sink yields 1.
- Successor indices ≥ MAX_NODES are undefined input and are not checked.

## Timing
- Reset values: `order_ready`, `query_valid`, `reply_ready`, `busy`, `result_valid` = 0; `result_data` = 0; `overflow` = 0; FSM in IDLE. Reset mid-run aborts in the same cycle. RAM contents are don't-care because CLEAR runs on the next `start`.
- `busy` is 1 from the cycle after `start` through the DONE cycle.
- Run length: 1 + MAX_NODES + CHANNELS + per-node cost + (CHANNELS+1) + 1 cycles.
- Per-node cost:
  - 3 cycles for a skipped node (accept + 2 read).
  - Otherwise 3 + query wait + 3 per successor beat (reply + RD + WR) + 1 for NEXT. An empty reply costs 1 beat.
- At most one successor RMW is in flight. `reply_ready` is low during RD/WR, so back-to-back beats to the same v see the prior write with no bypass needed.
- Valid/ready: a transfer occurs when both are high on a `clk` edge. `query_valid`/`query_data` hold until accepted.
- `overflow` is sticky until the next `start`, which clears it in its acceptance cycle.

## Test plan
- Diamond 0→1, 0→2, 1→3, 2→3, order 0,1,2,3, channels (0,3) and (1,3) → `result_data` = {1, 2}, `overflow`=0.
- AoC example graph (you→out) mapped to indices, CHANNELS=1 → result 5.
- COUNT_WIDTH=4, chain of 4 diamonds (true count 16) → result 15, `overflow[0]`=1; a second channel with count 1 shows `overflow[1]`=0.
- Node with `reply_empty` and zero-count nodes interleaved → no query issued for zero-count nodes (check `query_valid` never asserts for them); result unchanged. Stall `query_ready` for 5 cycles → query held stable.
- Assert `rst` during WAIT_REPLY → next cycle `busy`=0 and all handshakes low. Re-run the diamond → {1, 2}. `start` pulsed while busy → ignored.
